// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing the registered 2-bit select for a shared 4:1 datapath mux.
// Grants last up to BURST beats, then rotate; each transferred beat is acked to its requester.
module mux_sel_arbiter #(
    parameter int unsigned BURST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic [1:0] sel,
    output logic       sel_valid,
    input  logic       sel_ready,
    output logic [3:0] grant
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state;
    logic [1:0] ptr;
    logic [3:0] beats;

    // Returns {found, index} of the first set request scanning p, p+1, p+2, p+3 (mod 4).
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic       req_sel;
    logic       transfer;
    logic       last_beat;
    logic       rel;
    logic [1:0] ptr_rot;
    logic [2:0] win_idle;
    logic [2:0] win_rot;

    assign req_sel   = req[sel];
    assign transfer  = (state == StGrant) && sel_ready && req_sel;
    assign last_beat = (({1'b0, beats} + 5'd1) == 5'(BURST));
    assign rel       = (state == StGrant) && (!req_sel || (transfer && last_beat));
    assign ptr_rot   = sel + 2'd1;
    assign win_idle  = pick(req, ptr);
    assign win_rot   = pick(req, ptr_rot);

    // Reset gating keeps ack quiet during reset even before the first reset edge lands.
    assign ack = (rst_n && transfer) ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            sel       <= 2'd0;
            sel_valid <= 1'b0;
            grant     <= 4'b0000;
            ptr       <= 2'd0;
            beats     <= 4'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (win_idle[2]) begin
                        state     <= StGrant;
                        sel       <= win_idle[1:0];
                        sel_valid <= 1'b1;
                        grant     <= 4'b0001 << win_idle[1:0];
                        beats     <= 4'd0;
                    end
                end
                StGrant: begin
                    if (rel) begin
                        // Released channel sits at lowest priority for the re-arbitration.
                        ptr <= ptr_rot;
                        if (win_rot[2]) begin
                            sel   <= win_rot[1:0];
                            grant <= 4'b0001 << win_rot[1:0];
                            beats <= 4'd0;
                        end else begin
                            state     <= StIdle;
                            sel_valid <= 1'b0;
                            grant     <= 4'b0000;
                        end
                    end else if (transfer) begin
                        beats <= beats + 4'd1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    sel_valid <= 1'b0;
                    grant     <= 4'b0000;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ack_onehot: assert property (@(posedge clk) $onehot0(ack));
    a_grant_dec:  assert property (@(posedge clk)
        grant == (sel_valid ? (4'b0001 << sel) : 4'b0000));
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: vector table on a BURST=1 instance plus burst and
// mid-burst-reset sequences on BURST=3 and BURST=4 instances.
module tb_mux_sel_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst3, rst4;
    logic [3:0] req1, req3, req4;
    logic       rdy1, rdy3, rdy4;
    logic [3:0] ack1, ack3, ack4;
    logic [1:0] sel1, sel3, sel4;
    logic       val1, val3, val4;
    logic [3:0] gnt1, gnt3, gnt4;

    mux_sel_arbiter #(.BURST(1)) u1 (
        .clk(clk), .rst_n(rst1), .req(req1), .ack(ack1), .sel(sel1),
        .sel_valid(val1), .sel_ready(rdy1), .grant(gnt1)
    );
    mux_sel_arbiter #(.BURST(3)) u3 (
        .clk(clk), .rst_n(rst3), .req(req3), .ack(ack3), .sel(sel3),
        .sel_valid(val3), .sel_ready(rdy3), .grant(gnt3)
    );
    mux_sel_arbiter #(.BURST(4)) u4 (
        .clk(clk), .rst_n(rst4), .req(req4), .ack(ack4), .sel(sel4),
        .sel_valid(val4), .sel_ready(rdy4), .grant(gnt4)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl[$];
    int   errors;
    int   checks;

    task automatic add(input logic r, input logic [3:0] q, input logic y,
                       input logic [1:0] s, input logic v, input logic [3:0] a);
        vec_t e;
        e.rst_n = r; e.req = q; e.rdy = y; e.sel = s; e.valid = v; e.ack = a;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then compare mid-cycle.
    task automatic step(input int d, input string name, input int idx, input logic r,
                        input logic [3:0] q, input logic y, input logic [1:0] s,
                        input logic v, input logic [3:0] a);
        logic [1:0] as;
        logic       av;
        logic [3:0] aa;
        logic [3:0] ag;
        logic [3:0] eg;
        @(negedge clk);
        case (d)
            1:       begin rst1 = r; req1 = q; rdy1 = y; end
            3:       begin rst3 = r; req3 = q; rdy3 = y; end
            default: begin rst4 = r; req4 = q; rdy4 = y; end
        endcase
        #2;
        case (d)
            1:       begin as = sel1; av = val1; aa = ack1; ag = gnt1; end
            3:       begin as = sel3; av = val3; aa = ack3; ag = gnt3; end
            default: begin as = sel4; av = val4; aa = ack4; ag = gnt4; end
        endcase
        eg = v ? (4'b0001 << s) : 4'b0000;
        check({name, ".sel"},   idx, {2'b00, as}, {2'b00, s});
        check({name, ".valid"}, idx, {3'b000, av}, {3'b000, v});
        check({name, ".ack"},   idx, aa, a);
        check({name, ".grant"}, idx, ag, eg);
    endtask

    initial begin
        logic [1:0] es;
        errors = 0;
        checks = 0;
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        req1 = 4'b0000; req3 = 4'b0000; req4 = 4'b0000;
        rdy1 = 1'b0; rdy3 = 1'b0; rdy4 = 1'b0;

        // Reset held, then BURST=1 rotation with all requesters
        add(0, 4'b1111, 1, 2'd0, 0, 4'b0000);
        add(0, 4'b1111, 1, 2'd0, 0, 4'b0000);
        add(0, 4'b1111, 1, 2'd0, 0, 4'b0000);
        add(1, 4'b1111, 1, 2'd0, 0, 4'b0000);
        add(1, 4'b1111, 1, 2'd0, 1, 4'b0001);
        add(1, 4'b1111, 1, 2'd1, 1, 4'b0010);
        add(1, 4'b1111, 1, 2'd2, 1, 4'b0100);
        add(1, 4'b1111, 1, 2'd3, 1, 4'b1000);
        add(1, 4'b1111, 1, 2'd0, 1, 4'b0001);
        add(1, 4'b1111, 1, 2'd1, 1, 4'b0010);
        // Channel 2 withdraws into backpressure on requester 1
        add(1, 4'b0010, 0, 2'd2, 1, 4'b0000);
        for (int i = 0; i < 5; i++) add(1, 4'b0010, 0, 2'd1, 1, 4'b0000);
        add(1, 4'b0010, 1, 2'd1, 1, 4'b0010);
        add(1, 4'b0010, 1, 2'd1, 1, 4'b0010);
        // Withdrawal of granted channel 2 with channel 3 waiting
        add(1, 4'b1100, 0, 2'd1, 1, 4'b0000);
        add(1, 4'b1100, 0, 2'd2, 1, 4'b0000);
        add(1, 4'b1000, 1, 2'd2, 1, 4'b0000);
        add(1, 4'b1000, 0, 2'd3, 1, 4'b0000);
        // Withdrawal with nobody else waiting drops to idle
        add(1, 4'b0100, 0, 2'd3, 1, 4'b0000);
        add(1, 4'b0100, 0, 2'd2, 1, 4'b0000);
        add(1, 4'b0000, 1, 2'd2, 1, 4'b0000);
        add(1, 4'b0000, 1, 2'd2, 0, 4'b0000);
        add(1, 4'b0001, 1, 2'd2, 0, 4'b0000);
        add(1, 4'b0001, 1, 2'd0, 1, 4'b0001);

        foreach (tbl[i])
            step(1, "b1", i, tbl[i].rst_n, tbl[i].req, tbl[i].rdy,
                 tbl[i].sel, tbl[i].valid, tbl[i].ack);

        // BURST=3, requesters 0 and 2 alternate in bursts of three
        step(3, "b3", 0, 1, 4'b0101, 1, 2'd0, 0, 4'b0000);
        for (int k = 0; k < 9; k++) begin
            es = (((k / 3) % 2) == 1) ? 2'd2 : 2'd0;
            step(3, "b3", k + 1, 1, 4'b0101, 1, es, 1, 4'b0001 << es);
        end

        // BURST=4: move ptr to 1, take two beats on channel 1, then reset mid-burst
        step(4, "b4", 0, 1, 4'b0001, 1, 2'd0, 0, 4'b0000);
        step(4, "b4", 1, 1, 4'b0010, 1, 2'd0, 1, 4'b0000);
        step(4, "b4", 2, 1, 4'b0010, 1, 2'd1, 1, 4'b0010);
        step(4, "b4", 3, 1, 4'b0010, 1, 2'd1, 1, 4'b0010);
        step(4, "b4", 4, 0, 4'b1111, 1, 2'd1, 1, 4'b0000);
        step(4, "b4", 5, 1, 4'b1111, 1, 2'd0, 0, 4'b0000);
        for (int k = 0; k < 4; k++) step(4, "b4", 6 + k, 1, 4'b1111, 1, 2'd0, 1, 4'b0001);
        step(4, "b4", 10, 1, 4'b1111, 1, 2'd1, 1, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
